opcode_stream_deserializer: RTL



---
 rtl/gpu_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/opcode_stream_deserializer.sv | 96 +++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared constants and elaboration-time helpers for the GPU opcode front end.
// Imported by the opcode deserializer and by its FIFO.
package gpu_pkg;

    localparam int DEFAULT_IN_W     = 8;
    localparam int DEFAULT_OPCODE_W = 16;
    localparam int DEFAULT_DEPTH    = 4;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int beats_per_opcode(input int opcode_w, input int in_w);
        return opcode_w / in_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a fill level.
// A push into a full FIFO only succeeds when a pop happens in the same cycle.
module sync_fifo
    import gpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic [clog2(DEPTH+1)-1:0]     level,
    output logic                          full
);

    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int LVL_W = clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr];
    assign level    = count;

endmodule

// File: rtl/opcode_stream_deserializer.sv
// Assembles narrow input beats into opcodes and queues them for the core array.
// Supports re-sync, selectable beat order and sticky overflow reporting.
module opcode_stream_deserializer
    import gpu_pkg::*;
#(
    parameter int IN_W      = DEFAULT_IN_W,
    parameter int OPCODE_W  = DEFAULT_OPCODE_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          sync,
    input  logic                          clear_err,
    output logic [OPCODE_W-1:0]           op_data,
    output logic                          op_valid,
    input  logic                          op_ready,
    output logic [clog2(DEPTH+1)-1:0]     level,
    output logic                          partial,
    output logic                          overflow
);

    localparam int BEATS = beats_per_opcode(OPCODE_W, IN_W);
    localparam int CNT_W = clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]    beat_cnt;
    logic [CNT_W-1:0]    eff_cnt;
    logic [OPCODE_W-1:0] asm_reg;
    logic [OPCODE_W-1:0] base_word;
    logic [OPCODE_W-1:0] next_word;
    logic                word_done;
    logic                fifo_full;
    logic                fifo_pop;
    logic                drop;

    // A sync in the same cycle as a beat makes that beat the first of a fresh opcode.
    assign eff_cnt   = sync ? '0 : beat_cnt;
    assign base_word = sync ? '0 : asm_reg;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign next_word = (base_word << IN_W) | OPCODE_W'(in_data);
        end else begin : g_lsb_first
            always_comb begin
                next_word = base_word;
                next_word[int'(eff_cnt)*IN_W +: IN_W] = in_data;
            end
        end
    endgenerate

    assign word_done = in_valid && (eff_cnt == LAST_BEAT);
    assign fifo_pop  = op_valid && op_ready;
    assign drop      = word_done && fifo_full && !fifo_pop;

    // Beat counter and assembly register; a drop outranks clear_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            asm_reg  <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_valid) begin
                asm_reg  <= next_word;
                beat_cnt <= word_done ? '0 : eff_cnt + CNT_W'(1);
            end else if (sync) begin
                beat_cnt <= '0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
        end
    end

    assign partial = (beat_cnt != '0);

    sync_fifo #(
        .DATA_W (OPCODE_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (word_done),
        .wr_data  (next_word),
        .pop      (op_ready),
        .rd_data  (op_data),
        .rd_valid (op_valid),
        .level    (level),
        .full     (fifo_full)
    );

endmodule
